// File: rtl/dmaster_st_pkg.sv
// ---------------------------------------------------------------------------
// dmaster_st_pkg
// Shared types for the DDR3 EMIF debug-master Avalon-ST byte-stream blocks.
//   state_t : arbiter lock state (idle / packet locked to one source)
//   beat_t  : one stream beat as it leaves the arbiter {data, sop, eop, channel}
// ---------------------------------------------------------------------------
package dmaster_st_pkg;

   localparam int DATA_W_DEF = 8;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_LOCK = 1'b1
   } state_t;

   typedef struct packed {
      logic [DATA_W_DEF-1:0] data;
      logic                  sop;
      logic                  eop;
      logic                  channel;
   } beat_t;

endpackage

// File: rtl/dmaster_st_out_reg.sv
// ---------------------------------------------------------------------------
// dmaster_st_out_reg
// Single-entry registered valid/ready output stage. A new beat may be loaded
// whenever the stage is empty or the sink takes the current beat this cycle,
// which gives one beat per cycle while out_ready stays high.
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   load                  capture in_* this cycle (caller honours can_load)
//   in_data/sop/eop/chan  beat to capture
//   can_load              stage can accept a beat this cycle
//   out_ready             sink backpressure
//   out_valid/data/sop/eop/channel  registered beat
// ---------------------------------------------------------------------------
module dmaster_st_out_reg #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              load,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_sop,
   input  logic              in_eop,
   input  logic              in_channel,
   output logic              can_load,
   input  logic              out_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic              out_sop,
   output logic              out_eop,
   output logic              out_channel
);

   logic              vld_p1;
   logic [DATA_W-1:0] data_p1;
   logic              sop_p1;
   logic              eop_p1;
   logic              chan_p1;

   assign can_load = ~vld_p1 | out_ready;

   // Stage p1: registered output beat
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vld_p1  <= 1'b0;
         data_p1 <= '0;
         sop_p1  <= 1'b0;
         eop_p1  <= 1'b0;
         chan_p1 <= 1'b0;
      end else if (load) begin
         vld_p1  <= 1'b1;
         data_p1 <= in_data;
         sop_p1  <= in_sop;
         eop_p1  <= in_eop;
         chan_p1 <= in_channel;
      end else if (out_ready) begin
         vld_p1  <= 1'b0;
      end
   end

   assign out_valid   = vld_p1;
   assign out_data    = data_p1;
   assign out_sop     = sop_p1;
   assign out_eop     = eop_p1;
   assign out_channel = chan_p1;

endmodule

// File: rtl/dmaster_st_packet_arbiter.sv
// ---------------------------------------------------------------------------
// dmaster_st_packet_arbiter
// Two-input Avalon-ST packet arbiter feeding one 8-bit sink (normally the
// dmaster timing adapter). Round-robin between sources, locked for a whole
// packet, registered output, and a watchdog that drops the lock when the
// granted source goes quiet mid-packet.
// Ports:
//   clk, reset_n                      clock, asynchronous active-low reset
//   in0_* / in1_*                     source beats (valid/data/sop/eop) + ready
//   out_valid/data/sop/eop/channel    registered beat towards the sink
//   out_ready                         sink backpressure
//   busy                              packet lock held
//   timeout_err                       one-cycle pulse after a forced release
//   sop_err                           one-cycle pulse, aligned with the first
//                                     beat of a lock on out_*, when it lacked sop
// ---------------------------------------------------------------------------
module dmaster_st_packet_arbiter
   import dmaster_st_pkg::*;
#(
   parameter int DATA_W       = DATA_W_DEF,
   parameter int IDLE_TIMEOUT = 255,
   parameter int CNT_W        = (IDLE_TIMEOUT < 1) ? 1 : $clog2(IDLE_TIMEOUT + 1)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              in0_valid,
   input  logic [DATA_W-1:0] in0_data,
   input  logic              in0_sop,
   input  logic              in0_eop,
   output logic              in0_ready,
   input  logic              in1_valid,
   input  logic [DATA_W-1:0] in1_data,
   input  logic              in1_sop,
   input  logic              in1_eop,
   output logic              in1_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic              out_sop,
   output logic              out_eop,
   output logic              out_channel,
   input  logic              out_ready,
   output logic              busy,
   output logic              timeout_err,
   output logic              sop_err
);

   localparam logic             WD_EN   = (IDLE_TIMEOUT > 0);
   localparam logic [CNT_W-1:0] WD_MAX  = CNT_W'(IDLE_TIMEOUT);
   // The release fires in the idle cycle whose increment would reach the limit
   localparam logic [CNT_W-1:0] WD_LAST = WD_EN ? CNT_W'(IDLE_TIMEOUT - 1) : '0;

   state_t            state, state_nxt;
   logic              grant, grant_nxt;
   logic              last_grant, last_grant_nxt;
   logic              first_beat, first_beat_nxt;
   logic [CNT_W-1:0]  wd_cnt, wd_cnt_nxt;
   logic              timeout_nxt, sop_err_nxt;

   logic              can_load;
   logic              accept;
   logic              g_valid, g_sop, g_eop;
   logic [DATA_W-1:0] g_data;

   // Granted-source view
   assign g_valid = grant ? in1_valid : in0_valid;
   assign g_data  = grant ? in1_data  : in0_data;
   assign g_sop   = grant ? in1_sop   : in0_sop;
   assign g_eop   = grant ? in1_eop   : in0_eop;

   assign busy      = (state == ST_LOCK);
   assign in0_ready = busy & ~grant & can_load;
   assign in1_ready = busy &  grant & can_load;
   assign accept    = busy & g_valid & can_load;

   always_comb begin
      state_nxt      = state;
      grant_nxt      = grant;
      last_grant_nxt = last_grant;
      first_beat_nxt = first_beat;
      wd_cnt_nxt     = wd_cnt;
      timeout_nxt    = 1'b0;
      sop_err_nxt    = 1'b0;
      case (state)
         ST_IDLE: begin
            wd_cnt_nxt = '0;
            if (in0_valid | in1_valid) begin
               // Tie goes to the source that did not hold the last lock
               grant_nxt      = (in0_valid & in1_valid) ? ~last_grant : in1_valid;
               first_beat_nxt = 1'b1;
               state_nxt      = ST_LOCK;
            end
         end
         ST_LOCK: begin
            if (accept) begin
               wd_cnt_nxt     = '0;
               first_beat_nxt = 1'b0;
               sop_err_nxt    = first_beat & ~g_sop;
               if (g_eop) begin
                  state_nxt      = ST_IDLE;
                  last_grant_nxt = grant;
               end
            end else if (!g_valid) begin
               // Only source silence counts; sink backpressure never does
               if (WD_EN && (wd_cnt == WD_LAST)) begin
                  timeout_nxt    = 1'b1;
                  state_nxt      = ST_IDLE;
                  last_grant_nxt = grant;
                  wd_cnt_nxt     = '0;
               end else if (wd_cnt != WD_MAX) begin
                  wd_cnt_nxt = wd_cnt + 1'b1;
               end
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= ST_IDLE;
         grant       <= 1'b0;
         last_grant  <= 1'b1;
         first_beat  <= 1'b0;
         wd_cnt      <= '0;
         timeout_err <= 1'b0;
         sop_err     <= 1'b0;
      end else begin
         state       <= state_nxt;
         grant       <= grant_nxt;
         last_grant  <= last_grant_nxt;
         first_beat  <= first_beat_nxt;
         wd_cnt      <= wd_cnt_nxt;
         timeout_err <= timeout_nxt;
         sop_err     <= sop_err_nxt;
      end
   end

   dmaster_st_out_reg #(
      .DATA_W (DATA_W)
   ) u_out_reg (
      .clk         (clk),
      .reset_n     (reset_n),
      .load        (accept),
      .in_data     (g_data),
      .in_sop      (g_sop),
      .in_eop      (g_eop),
      .in_channel  (grant),
      .can_load    (can_load),
      .out_ready   (out_ready),
      .out_valid   (out_valid),
      .out_data    (out_data),
      .out_sop     (out_sop),
      .out_eop     (out_eop),
      .out_channel (out_channel)
   );

endmodule
